aes_vec_sequencer: RTL

- Synthesizable, parametrised stimulus sequencer that drives the AES_top core's input interface (AES_en, AES_data_in, AES_key_in) from an on-chip vector table.
- Captures AES_data_out on AES_data_out_valid into a result stream.
- Sits between a config/host port and AES_top. Replaces hand-timed testbench stimulus for on-silicon and gate-level power/VCD runs.
- Adds multi-vector depth, loop mode, timeout detection and optional post-enable input toggling.

---
 rtl/aes_vec_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/aes_vec_sequencer.sv
// Table-driven stimulus sequencer for the AES_top input interface, with result capture and timeout.
// Optional build macro AES_SEQ_TOGGLE_EN: drive an LFSR pattern on AES_data_in during GAP.
module aes_vec_sequencer #(
  parameter int DW       = 128,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int HOLD_CYC = 51,
  parameter int GAP_CYC  = 15,
  parameter int TIMEOUT  = 1024
) (
  input  logic          AES_clk,
  input  logic          AES_rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic [DW-1:0] cfg_key,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_mode,
  input  logic [AW:0]   num_vec,
  output logic          AES_en,
  output logic [DW-1:0] AES_data_in,
  output logic [DW-1:0] AES_key_in,
  input  logic [DW-1:0] AES_data_out,
  input  logic          AES_data_out_valid,
  output logic          res_valid,
  output logic [AW-1:0] res_idx,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [15:0]   vec_cnt
);

  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_GAP, S_NEXT} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] tbl_data [DEPTH];
  logic [DW-1:0] tbl_key  [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] last_idx;
  logic [AW:0]   nv_eff;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo_cnt;
  logic          captured;
  logic          stop_lat;
  logic          stop_eff;
  logic          wrap;
  logic          hit;
  logic          tmo_hit;
  logic [DW-1:0] gap_data;

`ifdef AES_SEQ_TOGGLE_EN
  localparam int REP = (DW + 31) / 32;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_nxt;
  logic [REP*32-1:0] lfsr_rep;

  // Galois form, right shift, taps x^32+x^22+x^2+x+1
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : '0);
    lfsr_rep = {REP{lfsr}};
    gap_data = lfsr_rep[DW-1:0];
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst)
      lfsr <= 32'h1;
    else if (state == S_GAP)
      lfsr <= lfsr_nxt;
  end
`else
  always_comb gap_data = AES_data_in;
`endif

  always_comb begin
    if (num_vec == '0)
      nv_eff = (AW+1)'(1);
    else if (num_vec > (AW+1)'(DEPTH))
      nv_eff = (AW+1)'(DEPTH);
    else
      nv_eff = num_vec;
    last_idx = AW'(nv_eff - (AW+1)'(1));
    wrap     = (idx == last_idx);
    stop_eff = stop_lat | stop;
    hit      = AES_data_out_valid && !captured && (state == S_DRIVE || state == S_WAIT);
    tmo_hit  = (state == S_WAIT) && !captured && !AES_data_out_valid &&
               (tmo_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_DRIVE;
      S_DRIVE: if (cnt == CW'(HOLD_CYC - 1)) state_nxt = S_WAIT;
      S_WAIT:  if (captured || AES_data_out_valid || tmo_hit) state_nxt = S_GAP;
      S_GAP:   if (cnt == CW'(GAP_CYC - 1)) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (stop_eff || (wrap && !loop_mode)) ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    AES_en = (state == S_DRIVE);
  end

  // Table is deliberately left out of reset so contents survive AES_rst.
  always_ff @(posedge AES_clk) begin
    if (cfg_we) begin
      tbl_data[cfg_addr] <= cfg_data;
      tbl_key[cfg_addr]  <= cfg_key;
    end
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      AES_data_in <= '0;
      AES_key_in  <= '0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_data    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      vec_cnt     <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      captured    <= 1'b0;
      stop_lat    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (state != S_IDLE && stop)
        stop_lat <= 1'b1;
      if (hit) begin
        res_valid <= 1'b1;
        res_data  <= AES_data_out;
        res_idx   <= idx;
        captured  <= 1'b1;
      end
      if (tmo_hit)
        timeout_err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          idx         <= '0;
          timeout_err <= 1'b0;
          vec_cnt     <= '0;
          stop_lat    <= 1'b0;
        end
        S_LOAD: begin
          AES_data_in <= tbl_data[idx];
          AES_key_in  <= tbl_key[idx];
          captured    <= 1'b0;
          tmo_cnt     <= '0;
        end
        S_DRIVE, S_WAIT:
          if (tmo_cnt != TW'(TIMEOUT - 1))
            tmo_cnt <= tmo_cnt + TW'(1);
        S_GAP:
          AES_data_in <= gap_data;
        S_NEXT: begin
          if (vec_cnt != '1)
            vec_cnt <= vec_cnt + 16'd1;
          // The stop-clear here must follow the generic latch above so it wins.
          if (state_nxt == S_IDLE) begin
            done     <= 1'b1;
            stop_lat <= 1'b0;
          end else begin
            idx <= wrap ? '0 : idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
